// File: rtl/sfm_tcdm_responder.sv
// -----------------------------------------------------------------------------
// sfm_tcdm_responder
//
// Single-port TCDM target serving the softmax streamer's load/store channels.
// Holds a word-addressed memory array, grants requests under a credit limit
// and returns exactly one in-order response per grant after a fixed pipeline
// latency, through a response FIFO with r_ready backpressure.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous flush of pipeline/FIFO/counters (memory kept)
//   tcdm_req_i/gnt_o    request valid / accepted this cycle (gnt combinational)
//   tcdm_add_i          byte address (word = add[off +: log2(DEPTH)], wraps)
//   tcdm_wen_i          1 = read, 0 = write
//   tcdm_be_i           byte enables for writes
//   tcdm_data_i         write data
//   tcdm_r_data_o       response data (0 for writes)
//   tcdm_r_valid_o      response valid (FIFO head)
//   tcdm_r_ready_i      response consumed
//   n_reads_o           granted read count (wraps)
//   n_writes_o          granted write count (wraps)
//
// Optional feature macro: SFM_TCDM_RESP_STALL_EN
//   When defined, a 16-bit Fibonacci LFSR seeded with STALL_SEED masks gnt on
//   cycles where lfsr[0] = 1, producing deterministic pseudo-random stalls.
// -----------------------------------------------------------------------------

package sfm_pkg;
   parameter int unsigned DATA_W = 32;
endpackage : sfm_pkg

module sfm_tcdm_responder #(
   parameter int unsigned DATA_WIDTH      = sfm_pkg::DATA_W,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DEPTH           = 1024,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned RESP_FIFO_DEPTH = 4,
   parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    tcdm_req_i,
   output logic                    tcdm_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
   input  logic                    tcdm_wen_i,
   input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
   output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
   output logic                    tcdm_r_valid_o,
   input  logic                    tcdm_r_ready_i,
   output logic [31:0]             n_reads_o,
   output logic [31:0]             n_writes_o
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

   logic [IDX_W-1:0]      word_idx;
   logic                  gnt;
   logic                  stall;
   logic                  rd_gnt;
   logic                  wr_gnt;
   logic                  push;
   logic                  pop;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [LATENCY-1:0]    pipe_vld_q,  pipe_vld_d;
   logic [DATA_WIDTH-1:0] pipe_data_q [LATENCY];
   logic [DATA_WIDTH-1:0] pipe_data_d [LATENCY];

   logic [DATA_WIDTH-1:0] fifo_data_q [RESP_FIFO_DEPTH];
   logic [PTR_W-1:0]      fifo_wptr_q, fifo_wptr_d;
   logic [PTR_W-1:0]      fifo_rptr_q, fifo_rptr_d;
   logic [CNT_W-1:0]      fifo_cnt_q,  fifo_cnt_d;
   logic [CNT_W-1:0]      outst_q,     outst_d;

   logic [31:0]           n_reads_q,  n_reads_d;
   logic [31:0]           n_writes_q, n_writes_d;

   logic                  unused_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RESP_FIFO_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Offset bits below the word and address bits above the array simply drop out.
   assign word_idx  = tcdm_add_i[OFF_W +: IDX_W];
   assign unused_ok = ^{tcdm_add_i, STALL_SEED};

`ifdef SFM_TCDM_RESP_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Taps 16,14,13,11 counted from the output end: with a right shift they
   // sit at bits 0,2,3,5 and the feedback enters at bit 15.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      if (clear_i) lfsr_d = STALL_SEED;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= STALL_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   // Credits count pipeline + FIFO entries from registered state only, so a
   // pop in this cycle frees its credit no earlier than the next cycle.
   assign gnt    = rst_ni & tcdm_req_i & ~clear_i & ~stall
                 & (outst_q < CNT_W'(RESP_FIFO_DEPTH));
   assign rd_gnt = gnt &  tcdm_wen_i;
   assign wr_gnt = gnt & ~tcdm_wen_i;

   assign push = pipe_vld_q[LATENCY-1];
   assign pop  = tcdm_r_valid_o & tcdm_r_ready_i;

   always_comb begin
      pipe_vld_d[0]  = gnt;
      pipe_data_d[0] = rd_gnt ? mem_q[word_idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_data_d[i] = pipe_data_q[i-1];
      end

      fifo_wptr_d = push ? ptr_inc(fifo_wptr_q) : fifo_wptr_q;
      fifo_rptr_d = pop  ? ptr_inc(fifo_rptr_q) : fifo_rptr_q;
      fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      outst_d     = outst_q    + CNT_W'(gnt)  - CNT_W'(pop);

      n_reads_d   = n_reads_q  + 32'(rd_gnt);
      n_writes_d  = n_writes_q + 32'(wr_gnt);

      if (clear_i) begin
         pipe_vld_d = '0;
         for (int unsigned i = 0; i < LATENCY; i++) pipe_data_d[i] = '0;
         fifo_wptr_d = '0;
         fifo_rptr_d = '0;
         fifo_cnt_d  = '0;
         outst_d     = '0;
         n_reads_d   = '0;
         n_writes_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_vld_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) pipe_data_q[i] <= '0;
         fifo_wptr_q <= '0;
         fifo_rptr_q <= '0;
         fifo_cnt_q  <= '0;
         outst_q     <= '0;
         n_reads_q   <= '0;
         n_writes_q  <= '0;
      end else begin
         pipe_vld_q <= pipe_vld_d;
         for (int unsigned i = 0; i < LATENCY; i++) pipe_data_q[i] <= pipe_data_d[i];
         fifo_wptr_q <= fifo_wptr_d;
         fifo_rptr_q <= fifo_rptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         outst_q     <= outst_d;
         n_reads_q   <= n_reads_d;
         n_writes_q  <= n_writes_d;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the pointers above.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) fifo_data_q[fifo_wptr_q] <= pipe_data_q[LATENCY-1];
   end

   always_ff @(posedge clk_i) begin
      if (wr_gnt) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (tcdm_be_i[b]) mem_q[word_idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
         end
      end
   end

   assign tcdm_gnt_o     = gnt;
   assign tcdm_r_valid_o = (fifo_cnt_q != '0);
   assign tcdm_r_data_o  = tcdm_r_valid_o ? fifo_data_q[fifo_rptr_q] : '0;
   assign n_reads_o      = n_reads_q;
   assign n_writes_o     = n_writes_q;

endmodule : sfm_tcdm_responder

// File: tb/tb_sfm_tcdm_responder.sv
`timescale 1ns/1ps
module tb_sfm_tcdm_responder;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam int unsigned DEP  = 1024;
   localparam int unsigned LAT  = 2;
   localparam int unsigned FD   = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          clear  = 1'b0;
   logic          req    = 1'b0;
   logic          wen    = 1'b0;
   logic          rready = 1'b1;
   logic [AW-1:0] add    = '0;
   logic [3:0]    be     = '0;
   logic [DW-1:0] wdata  = '0;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic [31:0]   n_reads;
   logic [31:0]   n_writes;

   int compared   = 0;
   int mismatched = 0;
   int edges      = 0;

   sfm_tcdm_responder #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .DEPTH           (DEP),
      .LATENCY         (LAT),
      .RESP_FIFO_DEPTH (FD),
      .STALL_SEED      (SEED)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear),
      .tcdm_req_i     (req),
      .tcdm_gnt_o     (gnt),
      .tcdm_add_i     (add),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be),
      .tcdm_data_i    (wdata),
      .tcdm_r_data_o  (rdata),
      .tcdm_r_valid_o (rvalid),
      .tcdm_r_ready_i (rready),
      .n_reads_o      (n_reads),
      .n_writes_o     (n_writes)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int            rdy;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         mq[$];
   logic [DW-1:0] mmem [DEP];
   logic [31:0]   m_nr   = '0;
   logic [31:0]   m_nw   = '0;
   logic [15:0]   m_lfsr = SEED;
   int            now    = 0;
   logic [DW-1:0] resp_log[$];

   always @(negedge clk) begin : model
      logic          e_valid;
      logic          e_gnt;
      logic          stall_bit;
      logic [DW-1:0] e_data;
      int            w;
      if (!rst_n) begin
         mq.delete();
         m_nr   = '0;
         m_nw   = '0;
         m_lfsr = SEED;
         chk("rst_gnt",    32'(gnt),    32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
         chk("rst_rdata",  rdata,       32'd0);
         chk("rst_nreads", n_reads,     32'd0);
         chk("rst_nwrites", n_writes,   32'd0);
      end else begin
         e_valid = (mq.size() != 0) && (mq[0].rdy <= now);
         e_data  = e_valid ? mq[0].data : '0;
         stall_bit = 1'b0;
`ifdef SFM_TCDM_RESP_STALL_EN
         stall_bit = m_lfsr[0];
`endif
         e_gnt = req && !clear && (mq.size() < int'(FD)) && !stall_bit;
         chk("m_gnt",    32'(gnt),    32'(e_gnt));
         chk("m_rvalid", 32'(rvalid), 32'(e_valid));
         if (e_valid) chk("m_rdata", rdata, e_data);
         chk("m_nreads",  n_reads,  m_nr);
         chk("m_nwrites", n_writes, m_nw);
         if (rvalid && rready) resp_log.push_back(rdata);
         if (clear) begin
            mq.delete();
            m_nr   = '0;
            m_nw   = '0;
            m_lfsr = SEED;
         end else begin
            if (e_valid && rready) void'(mq.pop_front());
            if (e_gnt) begin
               w = int'((add / (DW/8)) % DEP);
               if (wen) begin
                  mq.push_back('{now + 1 + int'(LAT), mmem[w]});
                  m_nr++;
               end else begin
                  for (int b = 0; b < int'(DW/8); b++)
                     if (be[b]) mmem[w][8*b +: 8] = wdata[8*b +: 8];
                  mq.push_back('{now + 1 + int'(LAT), '0});
                  m_nw++;
               end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
         end
      end
      now++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic xact(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                       input logic [DW-1:0] d, output int g_e);
      int   n = 0;
      logic g = 1'b0;
      req = 1'b1; wen = w; add = a; be = b; wdata = d;
      while (!g && n < 100) begin
         @(negedge clk); g = gnt;
         @(posedge clk); #1;
         n++;
      end
      req = 1'b0;
      g_e = edges;
      if (!g) begin
         compared++; mismatched++;
         $display("FAIL xact_timeout: got no gnt expected gnt within 100 cycles (add=%h)", a);
      end
   endtask

   task automatic wait_rv(input int g_e, output int lat, output logic [DW-1:0] d);
      int n = 0;
      lat = -1;
      d   = '0;
      while (n < 50) begin
         @(negedge clk);
         if (rvalid) begin
            lat = edges - g_e;
            d   = rdata;
            break;
         end
         n++;
      end
      if (lat < 0) begin
         compared++; mismatched++;
         $display("FAIL rvalid_timeout: got no r_valid expected r_valid within 50 cycles");
      end
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int            g_e;
      int            lat;
      int            issued;
      logic          g;
      logic [DW-1:0] d;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // full-word write then read back
      xact(1'b0, 32'h40, 4'hF, 32'hA5A5_A5A5, g_e);
      wait_rv(g_e, lat, d);
      chk("t1_wr_lat", lat, 32'd2);
      chk("t1_wr_data", d, 32'h0);
      xact(1'b1, 32'h40, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t1_rd_lat", lat, 32'd2);
      chk("t1_rd_data", d, 32'hA5A5_A5A5);
      chk("t1_n_writes", n_writes, 32'd1);
      chk("t1_n_reads", n_reads, 32'd1);

      // single-byte write merges into existing word
      xact(1'b0, 32'h40, 4'h1, 32'h0000_0011, g_e);
      wait_rv(g_e, lat, d);
      xact(1'b1, 32'h40, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t2_byte_merge", d, 32'hA5A5_A511);

      // credit limit with r_ready held low
      for (int k = 1; k <= 6; k++) begin
         xact(1'b0, 32'(k * 4), 4'hF, 32'h1000_0000 + 32'(k), g_e);
         wait_rv(g_e, lat, d);
      end
      resp_log.delete();
      rready = 1'b0;
      issued = 0;
      for (int c = 0; c < 40 && issued < 6; c++) begin
         req = 1'b1; wen = 1'b1; be = 4'h0; add = 32'((issued + 1) * 4);
         @(negedge clk); if (gnt) issued++;
         @(posedge clk); #1;
      end
      chk("t3_grants_held", 32'(issued), 32'd4);
      chk("t3_head_waiting", 32'(rvalid), 32'd1);
      rready = 1'b1;
      for (int c = 0; c < 40 && issued < 6; c++) begin
         req = 1'b1; wen = 1'b1; be = 4'h0; add = 32'((issued + 1) * 4);
         @(negedge clk); if (gnt) issued++;
         @(posedge clk); #1;
      end
      req = 1'b0;
      chk("t3_grants_total", 32'(issued), 32'd6);
      repeat (10) tick();
      chk("t3_resp_count", 32'(resp_log.size()), 32'd6);
      for (int k = 0; k < 6 && k < resp_log.size(); k++)
         chk("t3_resp_order", resp_log[k], 32'h1000_0001 + 32'(k));

      // address wrap and ignored offset bits
      xact(1'b1, 32'h1040, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t4_wrap", d, 32'hA5A5_A511);
      xact(1'b1, 32'h43, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t4_offset_43", d, 32'hA5A5_A511);
      xact(1'b1, 32'h07, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t4_offset_07", d, 32'h1000_0001);

      // clear with three responses outstanding and a competing request
      rready = 1'b0;
      xact(1'b1, 32'h04, 4'h0, 32'h0, g_e);
      xact(1'b1, 32'h08, 4'h0, 32'h0, g_e);
      xact(1'b1, 32'h0C, 4'h0, 32'h0, g_e);
      clear = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h40;
      @(negedge clk);
      chk("t5_gnt_in_clear", 32'(gnt), 32'd0);
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t5_rvalid_after", 32'(rvalid), 32'd0);
      chk("t5_nreads_after", n_reads, 32'd0);
      chk("t5_nwrites_after", n_writes, 32'd0);
      rready = 1'b1;
      g_e = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk); g = gnt;
         @(posedge clk); #1;
         if (g) begin g_e = edges; break; end
      end
      req = 1'b0;
      if (g_e < 0) begin
         compared++; mismatched++;
         $display("FAIL t5_gnt_timeout: got no gnt expected gnt after clear");
      end
      wait_rv(g_e, lat, d);
      chk("t5_first_lat", lat, 32'd2);
      chk("t5_mem_kept", d, 32'hA5A5_A511);

      // sustained request stream
      rready = 1'b1;
      issued = 0;
      for (int c = 0; c < 64; c++) begin
         req = 1'b1; wen = 1'b1; be = 4'h0; add = 32'(((issued % 6) + 1) * 4);
         @(negedge clk); if (gnt) issued++;
         @(posedge clk); #1;
      end
      req = 1'b0;
      repeat (8) tick();
`ifndef SFM_TCDM_RESP_STALL_EN
      chk("t6_stream_grants", 32'(issued), 32'd64);
`endif

      // asynchronous reset with responses in flight
      rready = 1'b0;
      xact(1'b1, 32'h40, 4'h0, 32'h0, g_e);
      xact(1'b1, 32'h40, 4'h0, 32'h0, g_e);
      req = 1'b1; wen = 1'b1; add = 32'h40;
      rst_n = 1'b0;
      #1;
      chk("t7_gnt_rst", 32'(gnt), 32'd0);
      chk("t7_rvalid_rst", 32'(rvalid), 32'd0);
      chk("t7_rdata_rst", rdata, 32'd0);
      chk("t7_nreads_rst", n_reads, 32'd0);
      req = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      rready = 1'b1;
      xact(1'b1, 32'h40, 4'h0, 32'h0, g_e);
      wait_rv(g_e, lat, d);
      chk("t7_mem_survives", d, 32'hA5A5_A511);
      chk("t7_lat", lat, 32'd2);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_sfm_tcdm_responder
